unidade_controle_jogo: RTL and testbench
========================================

UNIDADE_CONTROLE_JOGO -- requirements
Module: unidade_controle_jogo

Interface
REQ-001 The block SHALL have parameter TIMEOUT_HAB, default 1, which enables timeout handling (0 = fimT ignored).
REQ-002 The block SHALL have port clock  input  1  system clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-004 The block SHALL have port iniciar  input  1  level; requests start of a new round.
REQ-005 The block SHALL have port jogada  input  1  one-cycle pulse from the datapath edge detector; the player has pressed a button.
REQ-006 The block SHALL have port igual  input  1  datapath comparator; registered play equals memory word.
REQ-007 The block SHALL have port fimC  input  1  address counter at last position.
REQ-008 The block SHALL have port fimT  input  1  timeout counter reached its limit.
REQ-009 The block SHALL have outputs zeraC, contaC, zeraR, registraR, zeraT and contaT, each output 1, as counter/register/timer controls.
REQ-010 The block SHALL have outputs pronto, acertou, errou and timeout, each output 1, as round result flags.
REQ-011 The block SHALL have port db_estado  output  4  current state code for display.

Function
REQ-012 The block SHALL be a Moore FSM; outputs SHALL be decoded only from the state register.
REQ-013 The states and their codes SHALL be: inicial=0, preparacao=1, espera=2, registra=4, comparacao=5, proximo=6, fim_acerto=A, fim_timeout=D, fim_erro=E.
REQ-014 State inicial SHALL go to preparacao if iniciar=1, else stay in inicial.
REQ-015 State preparacao SHALL go unconditionally to espera.
REQ-016 State espera SHALL go to registra if jogada=1; otherwise to fim_timeout if fimT=1 and TIMEOUT_HAB=1; otherwise stay in espera.
REQ-017 If jogada=1 and fimT=1 occur in the same cycle, jogada SHALL win and the next state SHALL be registra.
REQ-018 State registra SHALL go unconditionally to comparacao.
REQ-019 State comparacao SHALL go to fim_erro if igual=0, to fim_acerto if igual=1 and fimC=1, and to proximo if igual=1 and fimC=0.
REQ-020 State proximo SHALL go unconditionally to espera.
REQ-021 Each fim_* state SHALL hold while iniciar=0 and SHALL go to preparacao when iniciar=1; a result flag stays visible until the next round starts.
REQ-022 Output decode SHALL be:
- zeraC, zeraR: high in inicial and preparacao.
- zeraT: high in inicial, preparacao and proximo.
- contaT: high in espera.
- registraR: high in registra.
- contaC: high in proximo.
- pronto: high in any fim_* state.
- acertou: high in fim_acerto only.
- errou: high in fim_erro only.
- timeout: high in fim_timeout only.
REQ-023 Latency from the jogada pulse in espera to the error or success verdict SHALL be 3 clock edges: espera->registra->comparacao->fim_*.
REQ-024 For a sequence of N words, the number of contaC pulses SHALL be N-1 on a full success.
REQ-025 db_estado SHALL equal the state code; an unused state code SHALL give db_estado=F and next state inicial.
REQ-026 jogada and iniciar SHALL be ignored in every state not listed as consuming them.

Reset
REQ-027 On reset=1 the state SHALL become inicial immediately, regardless of clock and current state, including mid-round.
REQ-028 Output values during and after reset SHALL be: zeraC=zeraR=zeraT=1, all other outputs 0, db_estado=0.

Structure
REQ-029 State codes SHALL live in a shared constants header reused by the datapath debug display and the testbench.
REQ-030 No sub-module SHALL be instantiated; the timer, the edge detector and the counters belong to the datapath.

Verification
REQ-031 Reset mid-round: reset pulse while in comparacao -> same-cycle state 0, db_estado=0, zeraC=1.
REQ-032 Full success, N=4, igual=1 on every play: iniciar then 4 jogada pulses -> contaC pulses=3, final state A, acertou=1, pronto=1.
REQ-033 Error on play 2: igual=0 at the second comparacao -> state E, errou=1, acertou=0, contaC pulses=1.
REQ-034 Timeout, no jogada after preparacao, fimT raised after 5 cycles -> state D, timeout=1; with TIMEOUT_HAB=0 -> remains in state 2.
REQ-035 Simultaneous jogada=1 and fimT=1 in espera -> next state 4, no timeout flag.
REQ-036 Restart from fim_erro: iniciar=1 -> state 1, errou drops to 0, zeraC=1.

Source files
------------

// File: rtl/unidade_controle_jogo_pkg.sv
// unidade_controle_jogo_pkg
// Shared constants for the game control unit: the FSM state type with its
// fixed display codes, plus the code shown when the state register holds a
// value outside the defined set. The datapath debug display and the
// testbench import this package so every party agrees on the codes.
package unidade_controle_jogo_pkg;

    typedef enum logic [3:0] {
        inicial     = 4'h0,
        preparacao  = 4'h1,
        espera      = 4'h2,
        registra    = 4'h4,
        comparacao  = 4'h5,
        proximo     = 4'h6,
        fim_acerto  = 4'hA,
        fim_timeout = 4'hD,
        fim_erro    = 4'hE
    } estado_t;

    localparam logic [3:0] DB_INVALIDO = 4'hF;

endpackage

// File: rtl/unidade_controle_jogo.sv
// unidade_controle_jogo
// Moore control unit for one round of the memory game. It clears the
// datapath, waits for each play, has the play registered and compared with
// the stored word, steps the address counter and ends in a result state
// that holds until a new round is requested.
//
// Ports
//   clock       system clock, rising edge
//   reset       asynchronous, active-high; forces state inicial
//   iniciar     level, start a new round
//   jogada      one-cycle pulse, player pressed a button
//   igual       registered play equals memory word
//   fimC        address counter at last position
//   fimT        timeout counter reached its limit
//   zeraC/contaC, zeraR/registraR, zeraT/contaT   datapath controls
//   pronto, acertou, errou, timeout               round result flags
//   db_estado   current state code for display
//
// Parameter TIMEOUT_HAB: 1 enables the timeout exit from espera, 0 ignores fimT.
module unidade_controle_jogo
    import unidade_controle_jogo_pkg::*;
#(
    parameter int TIMEOUT_HAB = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       jogada,
    input  logic       igual,
    input  logic       fimC,
    input  logic       fimT,
    output logic       zeraC,
    output logic       contaC,
    output logic       zeraR,
    output logic       registraR,
    output logic       zeraT,
    output logic       contaT,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic       timeout,
    output logic [3:0] db_estado
);

    localparam logic TIMEOUT_ATIVO = (TIMEOUT_HAB != 0);

    estado_t estado;
    estado_t estado_prox;

    // State register; reset takes effect immediately, even mid-round.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            estado <= inicial;
        else
            estado <= estado_prox;
    end

    // Next-state and Moore output decode. A play arriving together with the
    // timeout wins, because the jogada test comes first. Any code outside
    // the defined set shows F and falls back to inicial.
    always_comb begin
        estado_prox = estado;
        zeraC       = 1'b0;
        contaC      = 1'b0;
        zeraR       = 1'b0;
        registraR   = 1'b0;
        zeraT       = 1'b0;
        contaT      = 1'b0;
        pronto      = 1'b0;
        acertou     = 1'b0;
        errou       = 1'b0;
        timeout     = 1'b0;
        db_estado   = estado;

        case (estado)
            inicial: begin
                zeraC = 1'b1;
                zeraR = 1'b1;
                zeraT = 1'b1;
                if (iniciar)
                    estado_prox = preparacao;
            end
            preparacao: begin
                zeraC       = 1'b1;
                zeraR       = 1'b1;
                zeraT       = 1'b1;
                estado_prox = espera;
            end
            espera: begin
                contaT = 1'b1;
                if (jogada)
                    estado_prox = registra;
                else if (fimT && TIMEOUT_ATIVO)
                    estado_prox = fim_timeout;
            end
            registra: begin
                registraR   = 1'b1;
                estado_prox = comparacao;
            end
            comparacao: begin
                if (!igual)
                    estado_prox = fim_erro;
                else if (fimC)
                    estado_prox = fim_acerto;
                else
                    estado_prox = proximo;
            end
            proximo: begin
                contaC      = 1'b1;
                zeraT       = 1'b1;
                estado_prox = espera;
            end
            fim_acerto: begin
                pronto  = 1'b1;
                acertou = 1'b1;
                if (iniciar)
                    estado_prox = preparacao;
            end
            fim_timeout: begin
                pronto  = 1'b1;
                timeout = 1'b1;
                if (iniciar)
                    estado_prox = preparacao;
            end
            fim_erro: begin
                pronto = 1'b1;
                errou  = 1'b1;
                if (iniciar)
                    estado_prox = preparacao;
            end
            default: begin
                db_estado   = DB_INVALIDO;
                estado_prox = inicial;
            end
        endcase
    end

endmodule

// File: tb/tb_unidade_controle_jogo.sv
// tb_unidade_controle_jogo
// Directed bench for the game control unit. Each step drives inputs on the
// falling edge and queues the state expected after the next rising edge;
// the check pops that entry and compares the state code and every output.
// A second instance with the timeout disabled is compared during the
// timeout scenario.
module tb_unidade_controle_jogo;
    import unidade_controle_jogo_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic iniciar = 1'b0;
    logic jogada = 1'b0;
    logic igual = 1'b0;
    logic fimC = 1'b0;
    logic fimT = 1'b0;

    logic       zeraC, contaC, zeraR, registraR, zeraT, contaT;
    logic       pronto, acertou, errou, timeout;
    logic [3:0] db_estado;

    logic       zeraC_1, contaC_1, zeraR_1, registraR_1, zeraT_1, contaT_1;
    logic       pronto_1, acertou_1, errou_1, timeout_1;
    logic [3:0] db_estado_1;

    logic [9:0] saidas;
    assign saidas = {zeraC, contaC, zeraR, registraR, zeraT, contaT,
                     pronto, acertou, errou, timeout};

    always #5 clock = ~clock;

    unidade_controle_jogo dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .jogada(jogada),
        .igual(igual), .fimC(fimC), .fimT(fimT),
        .zeraC(zeraC), .contaC(contaC), .zeraR(zeraR), .registraR(registraR),
        .zeraT(zeraT), .contaT(contaT), .pronto(pronto), .acertou(acertou),
        .errou(errou), .timeout(timeout), .db_estado(db_estado)
    );

    unidade_controle_jogo #(.TIMEOUT_HAB(0)) dut_sem_timeout (
        .clock(clock), .reset(reset), .iniciar(iniciar), .jogada(jogada),
        .igual(igual), .fimC(fimC), .fimT(fimT),
        .zeraC(zeraC_1), .contaC(contaC_1), .zeraR(zeraR_1),
        .registraR(registraR_1), .zeraT(zeraT_1), .contaT(contaT_1),
        .pronto(pronto_1), .acertou(acertou_1), .errou(errou_1),
        .timeout(timeout_1), .db_estado(db_estado_1)
    );

    typedef struct {
        string      tag;
        logic [3:0] estado;
        logic [9:0] saidas;
    } esperado_t;

    esperado_t fila[$];
    int checks = 0;
    int errors = 0;
    int pulsos_contaC = 0;

    // Expected outputs for a state code, written straight from the decode
    // table: {zeraC,contaC,zeraR,registraR,zeraT,contaT,pronto,acertou,errou,timeout}.
    function automatic logic [9:0] decodifica(input logic [3:0] e);
        case (e)
            4'h0, 4'h1: return 10'b1_0_1_0_1_0_0_0_0_0;
            4'h2:       return 10'b0_0_0_0_0_1_0_0_0_0;
            4'h4:       return 10'b0_0_0_1_0_0_0_0_0_0;
            4'h5:       return 10'b0_0_0_0_0_0_0_0_0_0;
            4'h6:       return 10'b0_1_0_0_1_0_0_0_0_0;
            4'hA:       return 10'b0_0_0_0_0_0_1_1_0_0;
            4'hD:       return 10'b0_0_0_0_0_0_1_0_0_1;
            4'hE:       return 10'b0_0_0_0_0_0_1_0_1_0;
            default:    return 10'b0;
        endcase
    endfunction

    task automatic esperar(input logic [3:0] e, input string tag);
        esperado_t x;
        x.tag    = tag;
        x.estado = e;
        x.saidas = decodifica(e);
        fila.push_back(x);
    endtask

    task automatic checkOutput();
        esperado_t x;
        if (fila.size() == 0) begin
            checks++;
            errors++;
            $error("[TB] FAIL scoreboard_empty observed=none expected=entry");
        end else begin
            x = fila.pop_front();
            checks++;
            assert (db_estado === x.estado) else begin
                errors++;
                $error("[TB] FAIL %s db_estado observed=%h expected=%h", x.tag, db_estado, x.estado);
            end
            checks++;
            assert (saidas === x.saidas) else begin
                errors++;
                $error("[TB] FAIL %s outputs observed=%b expected=%b", x.tag, saidas, x.saidas);
            end
            if (contaC === 1'b1)
                pulsos_contaC++;
        end
    endtask

    task automatic applyStimulus(input logic ini, input logic jog, input logic ig,
                                 input logic fc, input logic ft,
                                 input logic [3:0] e, input string tag);
        @(negedge clock);
        iniciar = ini;
        jogada  = jog;
        igual   = ig;
        fimC    = fc;
        fimT    = ft;
        esperar(e, tag);
        @(posedge clock);
        #1;
        checkOutput();
    endtask

    task automatic checkPulsos(input int esperado, input string tag);
        checks++;
        assert (pulsos_contaC === esperado) else begin
            errors++;
            $error("[TB] FAIL %s contaC_pulses observed=%0d expected=%0d", tag, pulsos_contaC, esperado);
        end
    endtask

    initial begin
        $display("[TB] start");

        // Reset state
        #3;
        esperar(inicial, "reset");
        checkOutput();
        @(negedge clock);
        reset = 1'b0;
        applyStimulus(0, 1, 1, 0, 0, inicial, "inicial_ignores_jogada");

        // Full success, four words
        applyStimulus(1, 0, 0, 0, 0, preparacao, "ok_start");
        pulsos_contaC = 0;
        applyStimulus(0, 0, 0, 0, 0, espera, "ok_espera");
        for (int p = 1; p <= 3; p++) begin
            applyStimulus(0, 1, 1, 0, 0, registra, "ok_registra");
            applyStimulus(0, 0, 1, 0, 0, comparacao, "ok_comparacao");
            applyStimulus(0, 0, 1, 0, 0, proximo, "ok_proximo");
            applyStimulus(0, 0, 0, 0, 0, espera, "ok_back_espera");
        end
        applyStimulus(1, 1, 1, 1, 0, registra, "ok_last_registra_iniciar_ignored");
        applyStimulus(0, 0, 1, 1, 0, comparacao, "ok_last_comparacao");
        applyStimulus(0, 0, 1, 1, 0, fim_acerto, "ok_fim_acerto");
        applyStimulus(0, 1, 0, 0, 1, fim_acerto, "ok_hold");
        checkPulsos(3, "ok_pulses");

        // Error on the second play
        applyStimulus(1, 0, 0, 0, 0, preparacao, "err_start");
        pulsos_contaC = 0;
        applyStimulus(0, 0, 0, 0, 0, espera, "err_espera");
        applyStimulus(0, 1, 1, 0, 0, registra, "err_p1_registra");
        applyStimulus(0, 0, 1, 0, 0, comparacao, "err_p1_comparacao");
        applyStimulus(0, 0, 1, 0, 0, proximo, "err_p1_proximo");
        applyStimulus(0, 0, 0, 0, 0, espera, "err_p1_espera");
        applyStimulus(0, 1, 1, 0, 0, registra, "err_p2_registra");
        applyStimulus(0, 0, 0, 0, 0, comparacao, "err_p2_comparacao");
        applyStimulus(0, 0, 0, 1, 0, fim_erro, "err_fim_erro");
        applyStimulus(0, 0, 0, 0, 0, fim_erro, "err_hold");
        checkPulsos(1, "err_pulses");

        // Restart from fim_erro
        applyStimulus(1, 0, 0, 0, 0, preparacao, "restart");
        applyStimulus(0, 0, 0, 0, 0, espera, "restart_espera");

        // Timeout after five idle cycles; disabled instance must stay in espera
        for (int c = 0; c < 5; c++)
            applyStimulus(0, 0, 0, 0, 0, espera, "to_wait");
        applyStimulus(0, 0, 0, 0, 1, fim_timeout, "to_fim_timeout");
        checks++;
        assert (db_estado_1 === 4'h2 && timeout_1 === 1'b0) else begin
            errors++;
            $error("[TB] FAIL to_disabled db_estado observed=%h timeout=%b expected=2 timeout=0", db_estado_1, timeout_1);
        end
        applyStimulus(0, 0, 0, 0, 0, fim_timeout, "to_hold");

        // Simultaneous jogada and fimT in espera
        applyStimulus(1, 0, 0, 0, 0, preparacao, "sim_start");
        applyStimulus(0, 0, 0, 0, 0, espera, "sim_espera");
        applyStimulus(0, 1, 0, 0, 1, registra, "sim_jogada_wins");
        applyStimulus(0, 0, 1, 0, 0, comparacao, "sim_comparacao");

        // Reset pulse while in comparacao, checked before any clock edge
        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        esperar(inicial, "reset_mid_round");
        checkOutput();
        @(negedge clock);
        reset = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, inicial, "after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
